// File: rtl/controlador_soma_serial_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | controlador_soma_serial_if: start/busy/done handshake + operand bus   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface controlador_soma_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;

  modport master (output start, A, B, Cin, input busy, done, S, Cout);
  modport slave  (input start, A, B, Cin, output busy, done, S, Cout);
endinterface
`default_nettype wire

// File: rtl/controlador_soma_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | controlador_soma_serial: WIDTH-bit add done 2 bits/clock on one adder |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module somador2bits (
  input  wire logic [1:0] a,
  input  wire logic [1:0] b,
  input  wire logic       cin,
  output logic      [1:0] s,
  output logic            cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {2'b00, cin};
endmodule

module controlador_soma_serial #(
  parameter int WIDTH = 8
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  controlador_soma_serial_if.slave  bus
);
  localparam int c_steps = WIDTH / 2;
  localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_part;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic [1:0]         w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_part_next;
  logic               w_last;
  logic               w_busy;
  logic               w_done;

  somador2bits u_somador (
    .a    (r_a[1:0]),
    .b    (r_b[1:0]),
    .cin  (r_carry),
    .s    (w_sum),
    .cout (w_cout)
  );

  // New sum bits enter at the MSB end so the LSB pair lands at bit 0 after N steps
  generate
    if (WIDTH == 2) begin : g_part_narrow
      assign w_part_next = w_sum;
    end else begin : g_part_wide
      assign w_part_next = {w_sum, r_part[WIDTH-1:2]};
    end
  endgenerate

  assign w_last = (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_next = ST_RUN;
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_part  <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.Cin;
            r_cnt   <= '0;
          end
        end
        ST_RUN: begin
          r_a     <= r_a >> 2;
          r_b     <= r_b >> 2;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          r_part  <= w_part_next;
          // Results update only on the final step so S/Cout hold the previous sum during RUN
          if (w_last) begin
            r_s    <= w_part_next;
            r_cout <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.S    = r_s;
  assign bus.Cout = r_cout;
endmodule
`default_nettype wire

// File: tb/tb_controlador_soma_serial.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_controlador_soma_serial: scoreboard bench, WIDTH=8 and WIDTH=2     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_controlador_soma_serial;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [8:0] sb_q [$];
  logic [2:0] sb2_q [$];

  controlador_soma_serial_if #(.WIDTH(8)) bus8 ();
  controlador_soma_serial_if #(.WIDTH(2)) bus2 ();

  controlador_soma_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  controlador_soma_serial #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      if ((bus8.busy && bus8.done) || (bus2.busy && bus2.done)) begin
        n_err++;
        $display("FAIL busy_done_overlap busy8=%0b done8=%0b busy2=%0b done2=%0b",
                 bus8.busy, bus8.done, bus2.busy, bus2.done);
      end
    end
  end

  // Drives one WIDTH=8 operation, pushes its expected result, waits (bounded) for done
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output int busy_cycles, output logic got_done,
                        output logic s_stable, output logic [7:0] s, output logic cout);
    logic [7:0] prev_s;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.A     = a;
    bus8.B     = b;
    bus8.Cin   = cin;
    sb_q.push_back({1'b0, a} + {1'b0, b} + {8'd0, cin});
    prev_s = bus8.S;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.A     = ~a;
    bus8.B     = ~b;
    bus8.Cin   = ~cin;
    busy_cycles = 0;
    got_done    = 1'b0;
    s_stable    = 1'b1;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(negedge clk);
      if (bus8.done) got_done = 1'b1;
      else if (bus8.busy) begin
        busy_cycles++;
        if (bus8.S !== prev_s) s_stable = 1'b0;
      end
    end
    s    = bus8.S;
    cout = bus8.Cout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.Cin = 1'b0;
    bus2.start = 1'b0; bus2.A = '0; bus2.B = '0; bus2.Cin = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus8.busy, bus8.done, bus8.S, bus8.Cout} !== 11'd0) begin
      n_err++;
      $display("FAIL reset8 busy=%0b done=%0b S=%h Cout=%0b, want all 0",
               bus8.busy, bus8.done, bus8.S, bus8.Cout);
    end
    n_vec++;
    if ({bus2.busy, bus2.done, bus2.S, bus2.Cout} !== 5'd0) begin
      n_err++;
      $display("FAIL reset2 busy=%0b done=%0b S=%h Cout=%0b, want all 0",
               bus2.busy, bus2.done, bus2.S, bus2.Cout);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bc; logic gd, st, co; logic [7:0] s; logic [8:0] exp;
    do_op8(8'h5A, 8'h3C, 1'b0, bc, gd, st, s, co);
    n_vec++;
    if (!gd) begin n_err++; $display("FAIL basic_timeout done=0, want 1"); end
    n_vec++;
    if (bc !== 4) begin n_err++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
    n_vec++;
    if (!st) begin n_err++; $display("FAIL basic_s_hold S changed during RUN, want held 00"); end
    exp = sb_q.pop_front();
    n_vec++;
    if ({co, s} !== exp) begin
      n_err++; $display("FAIL basic_sum got %h want %h", {co, s}, exp);
    end
    @(negedge clk);
    n_vec++;
    if (bus8.done !== 1'b0) begin n_err++; $display("FAIL basic_done_pulse done=%0b want 0", bus8.done); end
  endtask

  task automatic test_carry();
    int bc; logic gd, st, co; logic [7:0] s; logic [8:0] exp;
    logic [7:0] av [2];
    logic [7:0] bv [2];
    av[0] = 8'hFF; bv[0] = 8'h00;
    av[1] = 8'hFF; bv[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      do_op8(av[k], bv[k], 1'b1, bc, gd, st, s, co);
      exp = sb_q.pop_front();
      n_vec++;
      if (!gd || {co, s} !== exp) begin
        n_err++; $display("FAIL carry_%0d got %h done=%0b want %h", k, {co, s}, gd, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, ndone, first_done;
    logic [8:0] exp;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'h01; bus8.B = 8'h02; bus8.Cin = 1'b0;
    sb_q.push_back(9'h003);
    cyc = 0; ndone = 0; first_done = 0;
    while (cyc < 40 && ndone < 2) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        bus8.A = 8'h10;
        sb_q.push_back(9'h012);
      end
      if (bus8.done) begin
        ndone++;
        exp = sb_q.pop_front();
        n_vec++;
        if ({bus8.Cout, bus8.S} !== exp) begin
          n_err++; $display("FAIL b2b_sum%0d got %h want %h", ndone, {bus8.Cout, bus8.S}, exp);
        end
        if (ndone == 1) first_done = cyc;
        else begin
          bus8.start = 1'b0;
          n_vec++;
          if (cyc - first_done !== 6) begin
            n_err++; $display("FAIL b2b_spacing got %0d want 6", cyc - first_done);
          end
        end
      end
    end
    bus8.start = 1'b0;
    n_vec++;
    if (ndone !== 2) begin n_err++; $display("FAIL b2b_timeout done pulses %0d want 2", ndone); end
  endtask

  task automatic test_midrun_reset();
    int bc; int seen; logic gd, st, co; logic [7:0] s; logic [8:0] exp;
    @(negedge clk);
    bus8.start = 1'b1; bus8.A = 8'h5A; bus8.B = 8'h3C; bus8.Cin = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bus8.busy, bus8.done, bus8.S, bus8.Cout} !== 11'd0) begin
      n_err++;
      $display("FAIL midrun_reset busy=%0b done=%0b S=%h Cout=%0b, want all 0",
               bus8.busy, bus8.done, bus8.S, bus8.Cout);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) seen++;
    end
    n_vec++;
    if (seen !== 0) begin n_err++; $display("FAIL midrun_no_done busy/done seen %0d cycles want 0", seen); end
    do_op8(8'hC3, 8'h7E, 1'b1, bc, gd, st, s, co);
    exp = sb_q.pop_front();
    n_vec++;
    if (!gd || {co, s} !== exp) begin
      n_err++; $display("FAIL midrun_after got %h done=%0b want %h", {co, s}, gd, exp);
    end
  endtask

  task automatic test_width2();
    int bc; logic gd; logic [2:0] exp;
    @(negedge clk);
    bus2.start = 1'b1; bus2.A = 2'b11; bus2.B = 2'b01; bus2.Cin = 1'b1;
    sb2_q.push_back(3'b101);
    @(posedge clk);
    #1;
    bus2.start = 1'b0; bus2.A = 2'b00; bus2.B = 2'b00; bus2.Cin = 1'b0;
    bc = 0; gd = 1'b0;
    for (int i = 0; i < 10 && !gd; i++) begin
      @(negedge clk);
      if (bus2.done) gd = 1'b1;
      else if (bus2.busy) bc++;
    end
    n_vec++;
    if (bc !== 1) begin n_err++; $display("FAIL w2_busy_cycles got %0d want 1", bc); end
    exp = sb2_q.pop_front();
    n_vec++;
    if (!gd || {bus2.Cout, bus2.S} !== exp) begin
      n_err++; $display("FAIL w2_sum got %b done=%0b want %b", {bus2.Cout, bus2.S}, gd, exp);
    end
  endtask

  task automatic test_random();
    int bc; logic gd, st, co; logic [7:0] s; logic [8:0] exp;
    for (int k = 0; k < 1000; k++) begin
      do_op8(8'($urandom), 8'($urandom), 1'($urandom), bc, gd, st, s, co);
      exp = sb_q.pop_front();
      n_vec++;
      if (!gd || bc !== 4 || {co, s} !== exp) begin
        n_err++;
        $display("FAIL rand_%0d got %h busy=%0d done=%0b want %h busy=4", k, {co, s}, bc, gd, exp);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_midrun_reset();
    test_width2();
    test_random();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
